serial_frame_rx: RTL

Receive end of the one-bit serial links that connect modules in the design. It samples a synchronous, one-bit-per-clock framed stream on `rx_in` and checks start, parity and stop bits. Each good frame is presented as a parallel word on a valid/ready output with a one-entry holding register. It pairs with the frame serializer that drives the same wire from the upstream module.

---
 rtl/serial_frame_rx.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: one-bit-per-clock framed receiver (start, LSB-first data, optional even parity, stop) into a one-entry output register.
// Latency DATA_W+2+PARITY_EN cycles start-to-valid; a good frame meeting a held, non-draining register is dropped with an overrun pulse.
module serial_frame_rx #(
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_in,
    output logic [DATA_W-1:0] rx_out_data,
    output logic              rx_out_valid,
    input  logic              rx_out_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_shift;
    logic                r_par_acc;
    logic                r_par_bit;
    logic [DATA_W-1:0]   r_data;
    logic                r_valid;
    logic                r_perr;
    logic                r_ferr;
    logic                r_ovr;

    logic                w_start;
    logic                w_shift_en;
    logic                w_par_en;
    logic                w_stop_ok;
    logic                w_stop_bad;
    logic                w_last_bit;
    logic                w_par_bad;
    logic                w_good;
    logic                w_load;
    logic                w_ovr;

    assign w_last_bit = (r_cnt == LAST_BIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_shift_en  = 1'b0;
        w_par_en    = 1'b0;
        w_stop_ok   = 1'b0;
        w_stop_bad  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!rx_in) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_shift_en = 1'b1;
                if (w_last_bit) begin
                    w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                w_par_en    = 1'b1;
                w_state_nxt = S_STOP;
            end
            S_STOP: begin
                if (rx_in) begin
                    w_stop_ok   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_stop_bad  = 1'b1;
                    w_state_nxt = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                // A held-low line must return high before another start bit counts.
                if (rx_in) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Priority: stop error (handled by w_stop_ok gating), then parity, then overrun.
    assign w_par_bad = (PARITY_EN != 0) && (r_par_bit != r_par_acc);
    assign w_good    = w_stop_ok && !w_par_bad;
    assign w_load    = w_good && (!r_valid || rx_out_ready);
    assign w_ovr     = w_good && r_valid && !rx_out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_shift   <= '0;
            r_par_acc <= 1'b0;
            r_par_bit <= 1'b0;
        end else begin
            if (w_start) begin
                r_cnt     <= '0;
                r_par_acc <= 1'b0;
            end
            if (w_shift_en) begin
                r_shift[r_cnt] <= rx_in;
                r_par_acc      <= r_par_acc ^ rx_in;
                r_cnt          <= w_last_bit ? '0 : r_cnt + CNT_W'(1);
            end
            if (w_par_en) begin
                r_par_bit <= rx_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_perr <= w_stop_ok && w_par_bad;
            r_ferr <= w_stop_bad;
            r_ovr  <= w_ovr;
            if (w_load) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && rx_out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_out_data  = r_data;
    assign rx_out_valid = r_valid;
    assign parity_err   = r_perr;
    assign frame_err    = r_ferr;
    assign overrun      = r_ovr;

endmodule
